// File: rtl/ram_march_bist_if.sv
`default_nettype none
// ============================================================================
// Module      : ram_march_bist_if
// Description : Single-port synchronous RAM access bus between the March BIST
//               initiator (master) and the RAM instance (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface ram_march_bist_if #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
);
    logic              ram_cs;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_data_in;
    logic [DATA_W-1:0] ram_data_out;

    modport master (
        output ram_cs,
        output ram_we,
        output ram_addr,
        output ram_data_in,
        input  ram_data_out
    );

    modport slave (
        input  ram_cs,
        input  ram_we,
        input  ram_addr,
        input  ram_data_in,
        output ram_data_out
    );
endinterface
`default_nettype wire

// File: rtl/ram_march_bist.sv
`default_nettype none
// ============================================================================
// Module      : ram_march_bist
// Description : 4-element March BIST initiator for a 2^ADDR_W x DATA_W
//               single-port synchronous RAM:
//                 M0 up W(P); M1 up R(P),W(~P); M2 down R(~P),W(P);
//                 M3 down R(P).
//               Reports pass/fail plus the first failing address/data.
//               Optional macro BIST_ERR_COUNT_EN adds a saturating mismatch
//               counter and lets the test run to completion; without it the
//               first mismatch ends the test.
// Revision    : 1.0 - initial release
// ============================================================================
module ram_march_bist #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 8
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              start,
    input  wire logic [DATA_W-1:0] pattern,
    ram_march_bist_if.master       ram,
    output logic                   busy,
    output logic                   done,
    output logic                   fail,
    output logic [ADDR_W-1:0]      fail_addr,
    output logic [DATA_W-1:0]      fail_data,
    output logic [DATA_W-1:0]      fail_expected
`ifdef BIST_ERR_COUNT_EN
    ,
    output logic [7:0]             err_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_WR   = 3'd1,
        S_RD   = 3'd2,
        S_CMP  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [ADDR_W-1:0] c_addr_max = '1;
    localparam logic [ADDR_W-1:0] c_addr_one = {{(ADDR_W-1){1'b0}}, 1'b1};

    state_t            r_state;
    logic [1:0]        r_elem;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_pattern;
    logic              r_cs;
    logic              r_we;
    logic [DATA_W-1:0] r_din;

    logic              w_up;
    logic              w_last;
    logic [ADDR_W-1:0] w_next_addr;
    logic [DATA_W-1:0] w_rd_exp;
    logic [DATA_W-1:0] w_wr_val;
    logic              w_mismatch;
    logic              w_stop;

    assign ram.ram_cs      = r_cs;
    assign ram.ram_we      = r_we;
    assign ram.ram_addr    = r_addr;
    assign ram.ram_data_in = r_din;

    // Elements 0/1 march upward, 2/3 downward
    assign w_up   = (r_elem < 2'd2);
    assign w_last = w_up ? (r_addr == c_addr_max) : (r_addr == '0);
    // Next element starts at 0 if it marches up (M1), else at the top (M2/M3)
    assign w_next_addr = w_last ? ((r_elem == 2'd0) ? '0 : c_addr_max)
                                : (w_up ? r_addr + c_addr_one : r_addr - c_addr_one);
    assign w_rd_exp   = (r_elem == 2'd2) ? ~r_pattern : r_pattern;
    assign w_wr_val   = (r_elem == 2'd1) ? ~r_pattern : r_pattern;
    assign w_mismatch = (ram.ram_data_out != w_rd_exp);
`ifdef BIST_ERR_COUNT_EN
    assign w_stop = (r_elem == 2'd3) && w_last;
`else
    assign w_stop = ((r_elem == 2'd3) && w_last) || w_mismatch;
`endif

    // March sequencer with registered RAM bus and status outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_elem        <= 2'd0;
            r_addr        <= '0;
            r_pattern     <= '0;
            r_cs          <= 1'b0;
            r_we          <= 1'b0;
            r_din         <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            fail          <= 1'b0;
            fail_addr     <= '0;
            fail_data     <= '0;
            fail_expected <= '0;
`ifdef BIST_ERR_COUNT_EN
            err_count     <= 8'd0;
`endif
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state       <= S_WR;
                        r_elem        <= 2'd0;
                        r_addr        <= '0;
                        r_pattern     <= pattern;
                        r_cs          <= 1'b1;
                        r_we          <= 1'b1;
                        r_din         <= pattern;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        fail          <= 1'b0;
                        fail_addr     <= '0;
                        fail_data     <= '0;
                        fail_expected <= '0;
`ifdef BIST_ERR_COUNT_EN
                        err_count     <= 8'd0;
`endif
                    end
                end
                S_WR: begin
                    r_addr <= w_next_addr;
                    r_cs   <= 1'b1;
                    if (r_elem == 2'd0 && !w_last) begin
                        r_we  <= 1'b1;
                        r_din <= r_pattern;
                    end else begin
                        // Every element after M0 begins each address with a read
                        r_state <= S_RD;
                        r_we    <= 1'b0;
                        r_din   <= '0;
                        if (w_last) begin
                            r_elem <= r_elem + 2'd1;
                        end
                    end
                end
                S_RD: begin
                    r_state <= S_CMP;
                    r_cs    <= 1'b0;
                    r_we    <= 1'b0;
                end
                S_CMP: begin
                    if (w_mismatch) begin
                        fail <= 1'b1;
                        if (!fail) begin
                            fail_addr     <= r_addr;
                            fail_data     <= ram.ram_data_out;
                            fail_expected <= w_rd_exp;
                        end
`ifdef BIST_ERR_COUNT_EN
                        if (err_count != 8'hFF) begin
                            err_count <= err_count + 8'd1;
                        end
`endif
                    end
                    if (w_stop) begin
                        r_state <= S_DONE;
                        r_addr  <= '0;
                        r_cs    <= 1'b0;
                        r_we    <= 1'b0;
                        r_din   <= '0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                    end else if (r_elem != 2'd3) begin
                        r_state <= S_WR;
                        r_cs    <= 1'b1;
                        r_we    <= 1'b1;
                        r_din   <= w_wr_val;
                    end else begin
                        r_state <= S_RD;
                        r_addr  <= w_next_addr;
                        r_cs    <= 1'b1;
                        r_we    <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_cs    <= 1'b0;
                    r_we    <= 1'b0;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_march_bist.sv
`default_nettype none
// ============================================================================
// Module      : tb_ram_march_bist
// Description : Directed self-checking bench for ram_march_bist with a 16x8
//               synchronous RAM model that can inject a stuck-at-1 on bit 0
//               of address 7.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ram_march_bist;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] pattern;
    logic       busy;
    logic       done;
    logic       fail;
    logic [3:0] fail_addr;
    logic [7:0] fail_data;
    logic [7:0] fail_expected;
`ifdef BIST_ERR_COUNT_EN
    logic [7:0] err_count;
`endif

    logic       fault_en;
    logic [7:0] mem [16];

    int checks   = 0;
    int failures = 0;
    int cnt;
    int cs_seen;
    logic       ok;
    logic       f_cs, f_we, f_done, f_fail;
    logic [3:0] f_addr;
    logic [7:0] f_din;

    ram_march_bist_if #(.ADDR_W(4), .DATA_W(8)) ram_bus ();

    ram_march_bist #(.ADDR_W(4), .DATA_W(8)) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .pattern       (pattern),
        .ram           (ram_bus),
        .busy          (busy),
        .done          (done),
        .fail          (fail),
        .fail_addr     (fail_addr),
        .fail_data     (fail_data),
        .fail_expected (fail_expected)
`ifdef BIST_ERR_COUNT_EN
        ,
        .err_count     (err_count)
`endif
    );

    always #5 clk = ~clk;

    // 16x8 synchronous RAM; faulty cell at address 7 has bit 0 stuck at 1
    always @(posedge clk) begin
        if (ram_bus.ram_cs) begin
            if (ram_bus.ram_we)
                mem[ram_bus.ram_addr] <= (fault_en && ram_bus.ram_addr == 4'd7)
                                         ? (ram_bus.ram_data_in | 8'h01) : ram_bus.ram_data_in;
            else
                ram_bus.ram_data_out <= mem[ram_bus.ram_addr];
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Start a run, snapshot the first busy cycle, then count busy cycles.
    // pulse_at: busy cycle where a stray start is pulsed; rst_at: busy cycle
    // where reset is asserted mid-cycle (0 disables either).
    task automatic run(input logic [7:0] pat, input int pulse_at, input int rst_at);
        start   = 1'b1;
        pattern = pat;
        @(negedge clk);
        start   = 1'b0;
        f_cs   = ram_bus.ram_cs;
        f_we   = ram_bus.ram_we;
        f_addr = ram_bus.ram_addr;
        f_din  = ram_bus.ram_data_in;
        f_done = done;
        f_fail = fail;
        cnt = 0;
        while (busy && cnt < 400) begin
            cnt++;
            if (cnt == pulse_at) begin
                start   = 1'b1;
                pattern = 8'hFF;
            end else begin
                start = 1'b0;
            end
            if (cnt == rst_at) begin
                #2 rst = 1'b1;
                #1;
                check("mid_rst_cs", {31'd0, ram_bus.ram_cs}, 32'd0);
                check("mid_rst_busy", {31'd0, busy}, 32'd0);
                check("mid_rst_we", {31'd0, ram_bus.ram_we}, 32'd0);
                @(negedge clk);
                rst = 1'b0;
                break;
            end
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic idle_cs(input int n);
        cs_seen = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (ram_bus.ram_cs !== 1'b0) cs_seen++;
        end
    endtask

    task automatic backdoor(input logic [7:0] pat);
        ok = 1'b1;
        for (int i = 0; i < 16; i++)
            if (mem[i] !== pat) ok = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        pattern  = 8'h00;
        fault_en = 1'b0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        check("rst_cs", {31'd0, ram_bus.ram_cs}, 32'd0);
        check("rst_we", {31'd0, ram_bus.ram_we}, 32'd0);
        check("rst_addr", {28'd0, ram_bus.ram_addr}, 32'd0);
        check("rst_din", {24'd0, ram_bus.ram_data_in}, 32'd0);
        check("rst_flags", {29'd0, busy, done, fail}, 32'd0);
        check("rst_fail_info", {12'd0, fail_addr, fail_data, fail_expected}, 32'd0);
        rst = 1'b0;
        idle_cs(5);
        check("idle_no_access", cs_seen, 32'd0);

        // Healthy RAM, pattern 55
        run(8'h55, 0, 0);
        check("p55_first_wr", {16'd0, 3'd0, f_cs, f_we, f_addr, f_din}, {16'd0, 3'd0, 1'b1, 1'b1, 4'd0, 8'h55});
        check("p55_busy_cycles", cnt, 32'd144);
        check("p55_done_fail", {30'd0, done, fail}, {30'd0, 1'b1, 1'b0});
        check("p55_done_bus", {27'd0, ram_bus.ram_cs, ram_bus.ram_addr}, 32'd0);
        backdoor(8'h55);
        check("p55_backdoor", {31'd0, ok}, 32'd1);

        // Stuck-at-1 at addr 7 bit 0, pattern AA
        fault_en = 1'b1;
        run(8'hAA, 0, 0);
`ifdef BIST_ERR_COUNT_EN
        check("flt_busy_cycles", cnt, 32'd144);
        check("flt_err_count", {24'd0, err_count}, 32'd2);
`else
        check("flt_busy_cycles", cnt, 32'd39);
`endif
        check("flt_done_fail", {30'd0, done, fail}, {30'd0, 1'b1, 1'b1});
        check("flt_fail_addr", {28'd0, fail_addr}, 32'd7);
        check("flt_fail_data", {24'd0, fail_data}, 32'hAB);
        check("flt_fail_expected", {24'd0, fail_expected}, 32'hAA);
        idle_cs(5);
        check("flt_no_access_after", cs_seen, 32'd0);

        // Restart from a failed DONE with pattern 0F on a healthy RAM
        fault_en = 1'b0;
        run(8'h0F, 0, 0);
        check("p0f_cleared_on_start", {29'd0, f_done, f_fail, f_cs}, {29'd0, 1'b0, 1'b0, 1'b1});
        check("p0f_first_din", {24'd0, f_din}, 32'h0F);
        check("p0f_busy_cycles", cnt, 32'd144);
        check("p0f_done_fail", {30'd0, done, fail}, {30'd0, 1'b1, 1'b0});
        check("p0f_fail_info", {12'd0, fail_addr, fail_data, fail_expected}, 32'd0);
        backdoor(8'h0F);
        check("p0f_backdoor", {31'd0, ok}, 32'd1);

        // Stray start at busy cycle 20 must be ignored (pattern not relatched)
        run(8'h55, 20, 0);
        check("pulse_busy_cycles", cnt, 32'd144);
        check("pulse_done_fail", {30'd0, done, fail}, {30'd0, 1'b1, 1'b0});
        backdoor(8'h55);
        check("pulse_backdoor", {31'd0, ok}, 32'd1);

        // Reset at busy cycle 50, then a clean run
        run(8'h33, 0, 50);
        check("post_rst_flags", {29'd0, busy, done, fail}, 32'd0);
        idle_cs(5);
        check("post_rst_no_access", cs_seen, 32'd0);
        run(8'h3C, 0, 0);
        check("p3c_busy_cycles", cnt, 32'd144);
        check("p3c_done_fail", {30'd0, done, fail}, {30'd0, 1'b1, 1'b0});
        backdoor(8'h3C);
        check("p3c_backdoor", {31'd0, ok}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ram_march_bist.md
Name: ram_march_bist

Overview:
- Built-in self-test initiator for the 16x8 single-port synchronous RAM; drives the RAM's cs/we/addr/data_in port and checks its data_out.
- Runs a 4-element March test (background pattern and its complement) on a start request, then reports pass/fail, first failing address and data.
- Sits between a test/debug controller and the RAM instance; the functional path is muxed away while busy (mux is outside this block).

Parameters:
- ADDR_W, 4, RAM address width; depth = 2^ADDR_W.
- DATA_W, 8, RAM data width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin test; sampled only in IDLE or DONE.
- pattern  input  DATA_W  background P; latched when start is accepted.
- ram_cs  output  1  RAM chip select.
- ram_we  output  1  RAM write enable.
- ram_addr  output  ADDR_W  RAM address.
- ram_data_in  output  DATA_W  write data to RAM.
- ram_data_out  input  DATA_W  RAM read data; valid the cycle after a read is issued.
- busy  output  1  test in progress.
- done  output  1  test finished; held until next accepted start.
- fail  output  1  at least one mismatch; valid when done=1.
- fail_addr  output  ADDR_W  address of first mismatch.
- fail_data  output  DATA_W  data read at first mismatch.
- fail_expected  output  DATA_W  expected data at first mismatch.

Behaviour:
- Reset (async): all outputs 0, FSM=IDLE, latched pattern 0. ram_cs drops immediately on rst, mid-run included; no further RAM access until a new start.
- RAM read model: cycle with ram_cs=1, ram_we=0, ram_addr=A issues the read; ram_data_out is compared in the following cycle.
- March elements (P = latched pattern, ~P = bitwise inverse):
  - M0 up: W(P).
  - M1 up: R(P), W(~P).
  - M2 down: R(~P), W(P).
  - M3 down: R(P).
  - "up" = addr 0..DEPTH-1; "down" = DEPTH-1..0.
- FSM states: IDLE, WR, RD, CMP, DONE.
- Per-address sequences:
  - M0: WR (1 cycle).
  - M1/M2: RD, CMP, WR (3 cycles).
  - M3: RD, CMP (2 cycles).
- Bus outputs by state:
  - WR: cs=1, we=1, data_in=expected write value.
  - RD: cs=1, we=0.
  - CMP: cs=0, we=0.
  - IDLE/DONE: cs=0, we=0, addr=0, data_in=0.
- Address counter wraps between elements (15->0 going up, 0->15 going down); element index advances at the wrap.
- Latency: start high in IDLE at edge N -> first WR (addr 0) in cycle N+1; busy is high for exactly 9*DEPTH = 144 cycles; DONE (done=1, busy=0) on the following cycle.
- Compare: in CMP, if ram_data_out != expected, then on the edge ending CMP:
  - set fail=1;
  - capture fail_addr/fail_data/fail_expected, first mismatch only.
- Accepting start in IDLE or DONE clears done, fail, fail_* and (if enabled) err_count, and latches pattern. start while busy is ignored.
- start held high continuously re-arms the test each time DONE is reached.

Optional Feature:
- Macro BIST_ERR_COUNT_EN.
- Defined:
  - adds output err_count[7:0], reset 0, saturating at 255;
  - increments on every CMP mismatch;
  - the test always runs all 144 cycles; fail_* still hold the first mismatch.
- Undefined:
  - no err_count port;
  - the first mismatch ends the test: the next state is DONE with fail=1, and no further RAM access.

Test Plan:
- Reset: assert rst mid-cycle -> all outputs 0 immediately; after release, 5 idle cycles with ram_cs=0.
- Healthy RAM, pattern=8'h55 -> busy exactly 144 cycles, done=1, fail=0; backdoor check: all 16 locations = 8'h55.
- RAM model with addr 7 bit0 stuck-at-1, pattern=8'hAA, macro off:
  - test stops at M1 addr 7;
  - fail=1, fail_addr=4'h7, fail_data=8'hAB, fail_expected=8'hAA;
  - done=1 on the cycle after that CMP.
- Same fault, macro on -> full 144 busy cycles, err_count=2 (M1 and M3 at addr 7), fail_* as above.
- start pulsed at busy cycle 20 -> ignored, run completes normally. start in DONE with pattern=8'h0F -> fail/done cleared, new run passes.
- rst asserted at busy cycle 50 -> ram_cs/busy 0 at once. A subsequent start with a healthy RAM completes with fail=0.
